// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel/window widths, FSM state type and window byte indexing
package img_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = PIX_W * WIN_TAPS;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  // Byte slot of tap (r,c) inside the flat window; r=0 oldest row, c=0 oldest column.
  function automatic int win_byte(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image row of storage, synchronous write, combinational read
module line_buffer #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster pixel stream to 3x3 neighbourhood windows, interior pixels only
module window_gen_3x3
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int CNT_W      = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PIX_W-1:0] i_pixel,
  input  logic             i_pixel_valid,
  input  logic             i_frame_start,
  output logic [WIN_W-1:0] o_window,
  output logic             o_window_valid,
  output logic             o_frame_done
);

  state_t state, state_nxt;
  logic [CNT_W-1:0] col, row, pos_col, pos_row;
  logic             restart, col_last, row_last, emit, done;
  logic [PIX_W-1:0] newer_q, older_q;
  logic [2:0][2:0][PIX_W-1:0] win_sr, win_nxt;
  logic [WIN_W-1:0] win_flat;

  assign restart = i_pixel_valid & i_frame_start;

  // Position of the pixel on the input this cycle; a restart or an idle block treats it as (0,0).
  always_comb begin
    pos_col = col;
    pos_row = row;
    if (restart || state == IDLE) begin
      pos_col = '0;
      pos_row = '0;
    end
  end

  assign col_last = (pos_col == CNT_W'(IMG_WIDTH - 1));
  assign row_last = (pos_row == CNT_W'(IMG_HEIGHT - 1));

  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(CNT_W), .DATA_W(PIX_W)) u_lb_newer (
    .i_clk   (i_clk),
    .wr_en   (i_pixel_valid),
    .addr    (pos_col),
    .wr_data (i_pixel),
    .rd_data (newer_q)
  );

  // The older row is fed from the newer row's read port, so the pair acts as a two-row cascade.
  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(CNT_W), .DATA_W(PIX_W)) u_lb_older (
    .i_clk   (i_clk),
    .wr_en   (i_pixel_valid),
    .addr    (pos_col),
    .wr_data (newer_q),
    .rd_data (older_q)
  );

  always_comb begin
    win_nxt  = '0;
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) win_nxt[r][c] = win_sr[r][c+1];
    end
    win_nxt[0][2] = older_q;
    win_nxt[1][2] = newer_q;
    win_nxt[2][2] = i_pixel;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) win_flat[win_byte(r, c)*PIX_W +: PIX_W] = win_nxt[r][c];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    done      = 1'b0;
    if (i_pixel_valid) begin
      if (restart) begin
        state_nxt = FILL;
      end else begin
        case (state)
          IDLE:    state_nxt = FILL;
          FILL:    if (pos_row == CNT_W'(1) && col_last) state_nxt = RUN;
          RUN: begin
            if (row_last && col_last) begin
              state_nxt = IDLE;
              done      = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
      emit = !restart && (pos_row >= CNT_W'(2)) && (pos_col >= CNT_W'(2));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col            <= '0;
      row            <= '0;
      win_sr         <= '0;
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      if (i_pixel_valid) begin
        col    <= col_last ? '0 : pos_col + CNT_W'(1);
        row    <= col_last ? (row_last ? '0 : pos_row + CNT_W'(1)) : pos_row;
        win_sr <= win_nxt;
      end
      if (emit) o_window <= win_flat;
      o_window_valid <= emit;
      o_frame_done   <= done;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - scoreboard bench for window_gen_3x3 on a 5x4 frame
module tb_window_gen_3x3;

  localparam int W = 5;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN = 72'h222120121110020100;
  localparam logic [71:0] LAST_WIN  = 72'h343332242322141312;

  typedef struct {
    logic [71:0] win;
    logic        done;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_pixel = '0;
  logic        i_pixel_valid = 1'b0;
  logic        i_frame_start = 1'b0;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        o_frame_done;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  logic [71:0] obs_win[$];
  logic        obs_done[$];
  logic        prev_acc = 1'b0;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(10)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pixel        (i_pixel),
    .i_pixel_valid  (i_pixel_valid),
    .i_frame_start  (i_frame_start),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .o_frame_done   (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[(rr*3+cc)*8 +: 8] = 8'((r - 2 + rr) * 16 + (c - 2 + cc));
    return w;
  endfunction

  function automatic int count_done(input int base);
    int n = 0;
    for (int i = base; i < obs_done.size(); i++) if (obs_done[i]) n++;
    return n;
  endfunction

  // Drive frame positions first..last (raster index), each followed by gap idle cycles.
  task automatic send_frame(input int first, input int last, input int gap, input bit fs_first);
    for (int i = first; i <= last; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      @(posedge i_clk);
      #1;
      i_pixel       = 8'(r * 16 + c);
      i_pixel_valid = 1'b1;
      i_frame_start = fs_first && (i == first);
      if (r >= 2 && c >= 2) begin
        exp_t e;
        e.win  = model_win(r, c);
        e.done = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        @(posedge i_clk);
        #1;
        i_pixel_valid = 1'b0;
        i_frame_start = 1'b0;
      end
    end
    @(posedge i_clk);
    #1;
    i_pixel_valid = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_window_valid) begin
        check_eq("valid_follows_pixel", 72'(prev_acc), 72'd1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 72'(o_window_valid), 72'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("window", o_window, e.win);
          check_eq("frame_done", 72'(o_frame_done), 72'(e.done));
        end
        obs_win.push_back(o_window);
        obs_done.push_back(o_frame_done);
      end else if (o_frame_done) begin
        check_eq("done_without_valid", 72'(o_window_valid), 72'd1);
      end
    end
    prev_acc = i_pixel_valid & i_rst_n;
  end

  initial begin
    int base;
    #1;
    check_eq("reset_window", o_window, 72'd0);
    check_eq("reset_valid", 72'(o_window_valid), 72'd0);
    check_eq("reset_done", 72'(o_frame_done), 72'd0);
    idle(2);
    i_rst_n = 1'b1;
    idle(2);

    // Continuous frame, no frame_start: first pixel taken as (0,0) from IDLE.
    base = obs_win.size();
    send_frame(0, W*H-1, 0, 1'b0);
    idle(3);
    check_eq("s1_count", 72'(obs_win.size() - base), 72'd6);
    check_eq("s1_first", obs_win[base], FIRST_WIN);
    check_eq("s1_last", obs_win[obs_win.size()-1], LAST_WIN);
    check_eq("s1_done_count", 72'(count_done(base)), 72'd1);

    // Valid toggling 1,0,0,1,...
    base = obs_win.size();
    send_frame(0, W*H-1, 2, 1'b0);
    idle(3);
    check_eq("s2_count", 72'(obs_win.size() - base), 72'd6);
    check_eq("s2_first", obs_win[base], FIRST_WIN);
    check_eq("s2_last", obs_win[obs_win.size()-1], LAST_WIN);

    // Back-to-back frames with frame_start.
    base = obs_win.size();
    send_frame(0, W*H-1, 0, 1'b1);
    send_frame(0, W*H-1, 0, 1'b1);
    idle(3);
    check_eq("s3_count", 72'(obs_win.size() - base), 72'd12);
    check_eq("s3_done_count", 72'(count_done(base)), 72'd2);
    check_eq("s3_second_first", obs_win[base+6], FIRST_WIN);

    // Restart at (2,3): frame 1 yields only its (2,2) window and no done.
    base = obs_win.size();
    send_frame(0, 2*W+2, 0, 1'b1);
    send_frame(0, W*H-1, 0, 1'b1);
    idle(3);
    check_eq("s4_count", 72'(obs_win.size() - base), 72'd7);
    check_eq("s4_done_count", 72'(count_done(base)), 72'd1);
    check_eq("s4_new_first", obs_win[base+1], FIRST_WIN);

    // Async reset mid-RUN, then a fresh frame.
    send_frame(0, 3*W+1, 0, 1'b1);
    idle(2);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_eq("s5_rst_valid", 72'(o_window_valid), 72'd0);
    check_eq("s5_rst_window", o_window, 72'd0);
    check_eq("s5_rst_done", 72'(o_frame_done), 72'd0);
    check_eq("s5_queue_drained", 72'(exp_q.size()), 72'd0);
    idle(2);
    i_rst_n = 1'b1;
    idle(1);
    base = obs_win.size();
    send_frame(0, W*H-1, 0, 1'b0);
    idle(3);
    check_eq("s5_count", 72'(obs_win.size() - base), 72'd6);
    check_eq("s5_first", obs_win[base], FIRST_WIN);
    check_eq("s5_last", obs_win[obs_win.size()-1], LAST_WIN);

    check_eq("final_queue_empty", 72'(exp_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
